// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of pipeline registers, each with a valid bit. Every stage can be
// stalled and flushed, and the chain reports how many stages are occupied.
// A stall in stage k holds stages 0..k and sends a bubble into stage k+1.
// A flush beats a stall. An empty stage always carries zero data, so it reads as a NOP.
// Defining PIPE_STAGE_CHAIN_PERF_EN adds the stall and flush event counters. Without it,
// both counter ports are tied to 0.
module pipe_stage_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    localparam int unsigned OCC_W = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [OCC_W-1:0]        occupancy,
    output logic [31:0]             stall_count,
    output logic [31:0]             flush_count
);

    logic [STAGES-1:0]             hold;
    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
    logic [OCC_W-1:0]              occ_q, occ_d;

    // A stage is held when it is stalled or when any stage downstream of it is stalled.
    always_comb begin
        logic acc;
        acc  = 1'b0;
        hold = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            acc     = acc | stall[i];
            hold[i] = acc;
        end
    end

    // Next state of each stage. Priority order: flush, then hold, then bubble, then load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        // Stage 0 takes the input when it is not held.
        if (flush[0]) begin
            valid_d[0] = 1'b0;
            data_d[0]  = '0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_valid ? in_data : '0;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else if (hold[i]) begin
                valid_d[i] = valid_q[i];
                data_d[i]  = data_q[i];
            end else if (hold[i-1]) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
            end else begin
                valid_d[i] = valid_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    // Occupancy is counted from the next-state valid bits, so the registered value lines up
    // with stage_valid on every cycle.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // Stage registers and occupancy register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

    assign in_ready    = ~hold[0];
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign occupancy   = occ_q;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        flush_hit;

    // A flush counts as an event only when it removes at least one valid entry.
    assign flush_hit = |(flush & valid_q);

    // Wrapping event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hold[0]) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_hit) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain. It uses a 4-stage instance and a 1-stage instance.
// The 4-stage instance is checked every cycle against a reference model. The model works out
// the next state from the highest stalled stage instead of per-stage hold bits.
module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int S = 4;

    logic          clk;
    logic          reset = 1'b1;

    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [S-1:0]  stall = '0;
    logic [S-1:0]  flush = '0;
    logic [S-1:0]  stage_valid;
    logic [S*W-1:0] stage_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [2:0]    occupancy;
    logic [31:0]   stall_count, flush_count;

    logic          in_valid1 = 1'b0;
    logic [W-1:0]  in_data1 = '0;
    logic          in_ready1;
    logic [0:0]    stall1 = '0;
    logic [0:0]    flush1 = '0;
    logic [0:0]    stage_valid1;
    logic [W-1:0]  stage_data1;
    logic          out_valid1;
    logic [W-1:0]  out_data1;
    logic [0:0]    occupancy1;
    logic [31:0]   stall_count1, flush_count1;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic          mv [S];
    logic [W-1:0]  md [S];
    int            mstall, mflush;

    pipe_stage_chain #(.WIDTH(W), .STAGES(S)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall), .flush(flush), .stage_valid(stage_valid),
        .stage_data(stage_data), .out_valid(out_valid), .out_data(out_data),
        .occupancy(occupancy), .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_stage_chain #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .stall(stall1), .flush(flush1), .stage_valid(stage_valid1),
        .stage_data(stage_data1), .out_valid(out_valid1), .out_data(out_data1),
        .occupancy(occupancy1), .stall_count(stall_count1), .flush_count(flush_count1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            mv[i] = 1'b0;
            md[i] = '0;
        end
        mstall = 0;
        mflush = 0;
    endtask

    // Next state from the spec rules. Stages up to the highest stalled stage k keep their
    // contents. Stage k+1 becomes a bubble. Stages above k+1 shift forward. Flush is applied last.
    task automatic model_step();
        logic         nv [S];
        logic [W-1:0] nd [S];
        int  k = -1;
        bit  hit = 0;
        for (int j = 0; j < S; j++) if (stall[j]) k = j;
        for (int i = 0; i < S; i++) begin
            if (i <= k) begin
                nv[i] = mv[i]; nd[i] = md[i];
            end else if (i == 0) begin
                nv[i] = in_valid; nd[i] = in_valid ? in_data : '0;
            end else if (i == k + 1) begin
                nv[i] = 1'b0; nd[i] = '0;
            end else begin
                nv[i] = mv[i-1]; nd[i] = md[i-1];
            end
            if (flush[i]) begin
                if (mv[i]) hit = 1;
                nv[i] = 1'b0; nd[i] = '0;
            end
        end
        if (k >= 0) mstall++;
        if (hit) mflush++;
        for (int i = 0; i < S; i++) begin
            mv[i] = nv[i];
            md[i] = nd[i];
        end
    endtask

    task automatic check_all(input string tag);
        int occ = 0;
        int exp_sc = 0;
        int exp_fc = 0;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        exp_sc = mstall;
        exp_fc = mflush;
`endif
        for (int i = 0; i < S; i++) begin
            chk($sformatf("%s.valid%0d", tag, i), 64'(stage_valid[i]), 64'(mv[i]));
            chk($sformatf("%s.data%0d", tag, i), 64'(stage_data[i*W +: W]), 64'(md[i]));
            occ += int'(mv[i]);
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(mv[S-1]));
        chk({tag, ".out_data"}, 64'(out_data), 64'(md[S-1]));
        chk({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(stall == '0));
        chk({tag, ".stall_count"}, 64'(stall_count), 64'(32'(exp_sc)));
        chk({tag, ".flush_count"}, 64'(flush_count), 64'(32'(exp_fc)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
        in_valid1 = 1'b0; in_data1 = '0; stall1 = '0; flush1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        chk("reset.dut1_valid", 64'(out_valid1), 64'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill(input logic [W-1:0] base);
        in_valid = 1'b1;
        for (int n = 0; n < S; n++) begin
            in_data = base + W'(n);
            tick();
            check_all("fill");
        end
        in_valid = 1'b0;
        in_data = '0;
    endtask

    initial begin
        model_reset();
        #2;
        // Reset takes effect immediately, with no clock edge.
        reset = 1'b0;
        #1;
        check_all("por");
        chk("por.out_data", 64'(out_data), 64'd0);
        chk("por.occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Stream 0x11..0x15 with no stalls.
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_data = 32'h11 + W'(n);
            tick();
            check_all("stream");
            if (n >= 3) begin
                chk("stream.out_data", 64'(out_data), 64'(32'h11 + n - 3));
                chk("stream.out_valid", 64'(out_valid), 64'd1);
                chk("stream.occ_full", 64'(occupancy), 64'd4);
            end
        end
        in_valid = 1'b0;
        tick();
        check_all("drain");

        // Stall stage 2 for two cycles while the pipe is full.
        do_reset();
        fill(32'h21);
        stall = 4'b0100;
        in_valid = 1'b1;
        in_data = 32'h25;
        #1;
        chk("stall.in_ready", 64'(in_ready), 64'd0);
        for (int n = 0; n < 2; n++) begin
            tick();
            check_all("stall");
            chk("stall.s3_valid", 64'(stage_valid[3]), 64'd0);
            chk("stall.s3_data", 64'(stage_data[3*W +: W]), 64'd0);
            chk("stall.s0_data", 64'(stage_data[0 +: W]), 64'h24);
            chk("stall.s2_data", 64'(stage_data[2*W +: W]), 64'h22);
        end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("stall.count", 64'(stall_count), 64'd2);
`else
        chk("stall.count_off", 64'(stall_count), 64'd0);
`endif
        idle_inputs();

        // A flush of stage 1 beats a stall of stage 3 in the same cycle.
        do_reset();
        fill(32'h31);
        flush = 4'b0010;
        stall = 4'b1000;
        tick();
        check_all("fvs");
        chk("fvs.s1_valid", 64'(stage_valid[1]), 64'd0);
        chk("fvs.s1_data", 64'(stage_data[W +: W]), 64'd0);
        chk("fvs.s0_data", 64'(stage_data[0 +: W]), 64'h34);
        chk("fvs.s3_data", 64'(stage_data[3*W +: W]), 64'h31);
        chk("fvs.occupancy", 64'(occupancy), 64'd3);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("fvs.flush_count", 64'(flush_count), 64'd1);
`else
        chk("fvs.flush_count_off", 64'(flush_count), 64'd0);
`endif
        idle_inputs();

        // Assert reset between clock edges while the pipe is full.
        do_reset();
        fill(32'h41);
        #3;
        reset = 1'b0;
        #1;
        chk("arst.stage_valid", 64'(stage_valid), 64'd0);
        chk("arst.out_data", 64'(out_data), 64'd0);
        chk("arst.occupancy", 64'(occupancy), 64'd0);
        model_reset();
        check_all("arst");
        #1;
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h55;
        tick();
        in_valid = 1'b0;
        in_data = '0;
        check_all("arst_rel");
        for (int n = 0; n < 3; n++) begin
            tick();
            check_all("arst_rel");
        end
        chk("arst.latency_data", 64'(out_data), 64'h55);
        chk("arst.latency_valid", 64'(out_valid), 64'd1);

        // Single-stage instance.
        do_reset();
        in_valid1 = 1'b1;
        in_data1 = 32'h5A;
        tick();
        chk("deg.load", 64'(out_data1), 64'h5A);
        in_data1 = 32'hAB;
        stall1 = 1'b1;
        #1;
        chk("deg.in_ready_stalled", 64'(in_ready1), 64'd0);
        tick();
        chk("deg.held_data", 64'(out_data1), 64'h5A);
        chk("deg.held_valid", 64'(out_valid1), 64'd1);
        stall1 = 1'b0;
        #1;
        chk("deg.in_ready", 64'(in_ready1), 64'd1);
        tick();
        chk("deg.out_data", 64'(out_data1), 64'hAB);
        chk("deg.stage_data", 64'(stage_data1), 64'hAB);
        chk("deg.occupancy", 64'(occupancy1), 64'd1);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
        chk("deg.stall_count", 64'(stall_count1), 64'd1);
`else
        chk("deg.stall_count_off", 64'(stall_count1), 64'd0);
`endif
        chk("deg.flush_count", 64'(flush_count1), 64'd0);
        chk("deg.valid_bit", 64'(stage_valid1), 64'd1);
        idle_inputs();

        // Random traffic with sparse stalls and flushes.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            for (int j = 0; j < S; j++) begin
                stall[j] = ($urandom_range(0, 9) == 0);
                flush[j] = ($urandom_range(0, 11) == 0);
            end
            tick();
            check_all("rand");
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
